mem_access_unit: RTL and testbench

- Memory-stage load/store sequencer that sits directly upstream of the writeback byte selector.
- Drives a word-only data memory through a req/ack handshake and stalls the pipeline while an access is in flight.
- Implements byte stores (STRB) as read-modify-write. Returns the raw 32-bit read word as ReadDataM; byte extraction for loads happens later in writeback.

---
 rtl/mem_access_pkg.sv | 19 +
 rtl/byte_lane_merge.sv | 22 ++
 rtl/mem_access_unit.sv | 135 +++++++++++++
 tb/tb_mem_access_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-stage load/store sequencer.
package mem_access_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StRmwRd,
    StWr,
    StDone
  } mau_state_e;

  localparam logic [1:0] LANE0 = 2'b00;
  localparam logic [1:0] LANE1 = 2'b01;
  localparam logic [1:0] LANE2 = 2'b10;
  localparam logic [1:0] LANE3 = 2'b11;

  localparam int unsigned ByteW = 8;

endpackage

// File: rtl/byte_lane_merge.sv
// Replaces one byte lane of a 32-bit word, leaving the other three bytes untouched.
module byte_lane_merge
  import mem_access_pkg::*;
(
  input  logic [31:0]      word,
  input  logic [ByteW-1:0] data_byte,
  input  logic [1:0]       lane,
  output logic [31:0]      merged
);

  always_comb begin
    merged = word;
    unique case (lane)
      LANE0:   merged[0*ByteW +: ByteW] = data_byte;
      LANE1:   merged[1*ByteW +: ByteW] = data_byte;
      LANE2:   merged[2*ByteW +: ByteW] = data_byte;
      LANE3:   merged[3*ByteW +: ByteW] = data_byte;
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store sequencer with read-modify-write byte stores.
// Optional ack timeout with sticky MemErrM is enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit
  import mem_access_pkg::*;
`ifdef MEM_ACCESS_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        ByteOpM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        StallM,
  output logic [31:0] ReadDataM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
`ifdef MEM_ACCESS_TIMEOUT_EN
  output logic        MemErrM,
`endif
  input  logic        mem_ack
);

  mau_state_e  state_q;
  logic [1:0]  lane_q;
  logic [31:0] merged_word;
  logic        req_valid;

  assign req_valid = MemReadM | MemWriteM;

  // Stall is combinational in IDLE so the requesting instruction is held the same cycle.
  assign StallM = reset & ((state_q == StIdle) ? req_valid : (state_q != StDone));

  // During RMW_RD, mem_wdata still holds the latched store data, so its low byte is the new byte.
  byte_lane_merge u_byte_lane_merge (
    .word      (mem_rdata),
    .data_byte (mem_wdata[ByteW-1:0]),
    .lane      (lane_q),
    .merged    (merged_word)
  );

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q;
  logic            timeout;

  assign timeout = mem_req & ~mem_ack & (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= '0;
      MemErrM  <= 1'b0;
    end else begin
      if (mem_req && !mem_ack && !timeout) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end else begin
        to_cnt_q <= '0;
      end
      if (timeout) begin
        MemErrM <= 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lane_q    <= LANE0;
      ReadDataM <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM & ~ByteOpM;
            mem_addr  <= ALUResultM[31:2];
            mem_wdata <= WriteDataM;
            lane_q    <= ALUResultM[1:0];
            if (!MemWriteM) begin
              state_q <= StRd;
            end else if (ByteOpM) begin
              state_q <= StRmwRd;
            end else begin
              state_q <= StWr;
            end
          end
        end
        StRd: begin
          if (mem_ack) begin
            ReadDataM <= mem_rdata;
            mem_req   <= 1'b0;
            state_q   <= StDone;
          end
        end
        StRmwRd: begin
          if (mem_ack) begin
            mem_wdata <= merged_word;
            mem_we    <= 1'b1;
            state_q   <= StWr;
          end
        end
        StWr: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
`ifdef MEM_ACCESS_TIMEOUT_EN
      // Abort wins over any wait-state progress; an aborted RMW never issues its write.
      if (timeout) begin
        state_q <= StDone;
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: memory responder model plus directed accesses.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        MemReadM;
  logic        MemWriteM;
  logic        ByteOpM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        StallM;
  logic [31:0] ReadDataM;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
`ifdef MEM_ACCESS_TIMEOUT_EN
  logic        MemErrM;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model and expectations shared between driver and responder.
  logic [31:0] mem_model [logic [29:0]];
  bit          exp_we_q [$];
  logic [29:0] exp_addr    = '0;
  logic [31:0] exp_wdata   = '0;
  logic [31:0] exp_rd      = '0;
  logic [31:0] rd_next     = '0;
  bit          rd_pending  = 1'b0;
  bit          exp_is_load = 1'b0;
  int          ack_delay   = 0;
  int          wait_cnt    = 0;
  int          wr_acks     = 0;
  logic [29:0] last_addr   = '0;
  logic [31:0] held_wdata  = '0;

`ifdef MEM_ACCESS_TIMEOUT_EN
  mem_access_unit #(
    .TIMEOUT_CYCLES (4),
    .TO_W           (8)
  ) dut (
`else
  mem_access_unit dut (
`endif
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .ByteOpM    (ByteOpM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .StallM     (StallM),
    .ReadDataM  (ReadDataM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
`ifdef MEM_ACCESS_TIMEOUT_EN
    .MemErrM    (MemErrM),
`endif
    .mem_ack    (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [29:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return 32'h0;
  endfunction

  // Byte merge by masking and shifting.
  function automatic logic [31:0] merge_ref(input logic [31:0] w, input logic [7:0] b,
                                            input logic [1:0] lane);
    int sh;
    sh = 8 * int'(lane);
    return (w & ~(32'hFF << sh)) | ({24'h0, b} << sh);
  endfunction

  // Memory responder and per-cycle compare process.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0BAD0BAD;
    @(posedge reset);
    forever begin
      @(negedge clk);
      if (rd_pending) begin
        exp_rd     = rd_next;
        rd_pending = 1'b0;
      end
      check("ReadDataM_track", ReadDataM, exp_rd);
      mem_ack   = 1'b0;
      mem_rdata = 32'h0BAD0BAD;
      if (!mem_req) begin
        wait_cnt = 0;
      end else begin
        check("stall_during_req", 32'(StallM), 32'd1);
        check("mem_addr", 32'(mem_addr), 32'(exp_addr));
        check("req_expected", 32'(exp_we_q.size() != 0), 32'd1);
        if (exp_we_q.size() != 0) begin
          check("mem_we", 32'(mem_we), 32'(exp_we_q[0]));
          if (wait_cnt == 0) held_wdata = mem_wdata;
          else check("wdata_stable", mem_wdata, held_wdata);
          if (wait_cnt >= ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_rd(mem_addr);
            last_addr = mem_addr;
            if (mem_we) begin
              check("mem_wdata", mem_wdata, exp_wdata);
              mem_model[mem_addr] = mem_wdata;
              wr_acks++;
            end else if (exp_is_load) begin
              rd_next    = mem_rdata;
              rd_pending = 1'b1;
            end
            void'(exp_we_q.pop_front());
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  // Presents one instruction until the DONE cycle and checks its total latency.
  task automatic access(input bit rd, input bit wr, input bit bop, input logic [31:0] addr,
                        input logic [31:0] data, input int delay, input int exp_lat,
                        input int exp_left, input string name);
    int lat;
    @(negedge clk);
    ack_delay   = delay;
    exp_addr    = addr[31:2];
    exp_is_load = rd && !wr;
    exp_we_q.delete();
    if (wr && bop) begin
      exp_we_q.push_back(1'b0);
      exp_we_q.push_back(1'b1);
      exp_wdata = merge_ref(mem_rd(addr[31:2]), data[7:0], addr[1:0]);
    end else if (wr) begin
      exp_we_q.push_back(1'b1);
      exp_wdata = data;
    end else begin
      exp_we_q.push_back(1'b0);
    end
    MemReadM   = rd;
    MemWriteM  = wr;
    ByteOpM    = bop;
    ALUResultM = addr;
    WriteDataM = data;
    lat = 1;
    #1;
    while (StallM && lat < 60) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_phases_left"}, 32'(exp_we_q.size()), 32'(exp_left));
    exp_we_q.delete();
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
    ByteOpM   = 1'b0;
  endtask

  initial begin
    int wr_before;
    reset      = 1'b0;
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    ByteOpM    = 1'b0;
    ALUResultM = '0;
    WriteDataM = '0;
    mem_model[30'h040] = 32'hDEADBEEF;
    mem_model[30'h081] = 32'h01010101;
    mem_model[30'h0C0] = 32'h11223344;
    mem_model[30'h100] = 32'hFFFFFFFF;
    mem_model[30'h101] = 32'hFFFFFFFF;
    mem_model[30'h102] = 32'hFFFFFFFF;
    mem_model[30'h180] = 32'h99887766;
    mem_model[30'h1C0] = 32'h77777777;

    #2;
    check("rst_StallM", 32'(StallM), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_ReadDataM", ReadDataM, 32'd0);
`ifdef MEM_ACCESS_TIMEOUT_EN
    check("rst_MemErrM", 32'(MemErrM), 32'd0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Load, immediate ack.
    access(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 0, 3, 0, "load1");
    check("load1_data", ReadDataM, 32'hDEADBEEF);
    check("load1_word_addr", 32'(last_addr), 32'h40);

    // Word store with three wait cycles.
    access(1'b0, 1'b1, 1'b0, 32'h204, 32'hCAFEF00D, 3, 6, 0, "wstore");
    check("wstore_mem", mem_rd(30'h081), 32'hCAFEF00D);
    check("wstore_rd_kept", ReadDataM, 32'hDEADBEEF);

    // Byte store into lane 2; upper WriteDataM bits must be ignored.
    access(1'b0, 1'b1, 1'b1, 32'h302, 32'h123456A5, 0, 4, 0, "bstore_l2");
    check("bstore_l2_mem", mem_rd(30'h0C0), 32'h11A53344);

    access(1'b0, 1'b1, 1'b1, 32'h400, 32'h0, 0, 4, 0, "bstore_l0");
    access(1'b0, 1'b1, 1'b1, 32'h405, 32'h0, 1, 6, 0, "bstore_l1");
    access(1'b0, 1'b1, 1'b1, 32'h40B, 32'h0, 0, 4, 0, "bstore_l3");
    check("bstore_l0_mem", mem_rd(30'h100), 32'hFFFFFF00);
    check("bstore_l1_mem", mem_rd(30'h101), 32'hFFFF00FF);
    check("bstore_l3_mem", mem_rd(30'h102), 32'h00FFFFFF);

    // Unaligned word load ignores addr[1:0].
    access(1'b1, 1'b0, 1'b0, 32'h301, 32'h0, 0, 3, 0, "load_unal");
    check("load_unal_data", ReadDataM, 32'h11A53344);

    // Read and write both asserted: the store wins.
    access(1'b1, 1'b1, 1'b0, 32'h500, 32'h55AA55AA, 0, 3, 0, "rw_both");
    check("rw_both_mem", mem_rd(30'h140), 32'h55AA55AA);
    check("rw_both_rd_kept", ReadDataM, 32'h11A53344);

    // Reset while RMW_RD is waiting for its ack.
    @(negedge clk);
    ack_delay   = 10;
    exp_addr    = 30'h180;
    exp_is_load = 1'b0;
    exp_we_q.delete();
    exp_we_q.push_back(1'b0);
    exp_we_q.push_back(1'b1);
    MemWriteM  = 1'b1;
    ByteOpM    = 1'b1;
    ALUResultM = 32'h601;
    WriteDataM = 32'h000000EE;
    repeat (2) @(negedge clk);
    #1;
    wr_before  = wr_acks;
    reset      = 1'b0;
    exp_rd     = 32'h0;
    rd_pending = 1'b0;
    #1;
    check("rst_mid_mem_req", 32'(mem_req), 32'd0);
    check("rst_mid_StallM", 32'(StallM), 32'd0);
    check("rst_mid_ReadDataM", ReadDataM, 32'd0);
    exp_we_q.delete();
    MemWriteM = 1'b0;
    ByteOpM   = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_mid_no_write", 32'(wr_acks), 32'(wr_before));
    check("rst_mid_mem_unchanged", mem_rd(30'h180), 32'h99887766);

    // Load after reset, one wait cycle.
    access(1'b1, 1'b0, 1'b0, 32'h500, 32'h0, 1, 4, 0, "load_post_rst");
    check("load_post_rst_data", ReadDataM, 32'h55AA55AA);

`ifdef MEM_ACCESS_TIMEOUT_EN
    // Never acked: aborts after four wait cycles, read phase left unfinished.
    access(1'b1, 1'b0, 1'b0, 32'h700, 32'h0, 1000, 6, 1, "load_timeout");
    check("timeout_err", 32'(MemErrM), 32'd1);
    check("timeout_rd_kept", ReadDataM, 32'h55AA55AA);
    access(1'b1, 1'b0, 1'b0, 32'h700, 32'h0, 0, 3, 0, "load_after_to");
    check("after_to_data", ReadDataM, 32'h77777777);
    check("after_to_err_sticky", 32'(MemErrM), 32'd1);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
